// File: rtl/mips_memory.sv
// Unified word-addressed memory for a MIPS core: a registered instruction read port,
// a read-first data port, a loader handshake, an optional post-reset clear and sticky error flags.
module mips_memory #(
  parameter int unsigned depth_words    = 1024,
  parameter logic [31:0] base_addr      = 32'h0000_0000,
  parameter bit          clear_on_reset = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic        data_rd_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        err_misaligned,
  output logic        err_range
);

  localparam int AW = $clog2(depth_words);
  localparam int P_INSTR = 0;
  localparam int P_DATA  = 1;
  localparam int P_LOAD  = 2;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   data_q, data_d;
  logic          err_mis_q, err_mis_d;
  logic          err_rng_q, err_rng_d;

  logic [31:0]   mem [depth_words];

  logic [31:0]   port_addr [3];
  logic [AW-1:0] port_idx  [3];
  logic          port_inr  [3];
  logic          port_mis  [3];

  logic          ready;
  logic          xfer;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  assign port_addr[P_INSTR] = instr_addr;
  assign port_addr[P_DATA]  = data_addr;
  assign port_addr[P_LOAD]  = load_addr;

  // base_addr is aligned to the memory size, so the offset's low bits equal the address's low bits.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dec
      logic [31:0] off;
      assign off           = port_addr[gi] - base_addr;
      assign port_idx[gi]  = off[AW+1:2];
      assign port_inr[gi]  = (off[31:AW+2] == '0);
      assign port_mis[gi]  = |off[1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(depth_words - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= clear_on_reset ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The loader only gets the single write port when the data port is not writing in range.
  assign ready      = (state_q == ST_READY) && !reset;
  assign load_ready = ready && (data_rd_wr || !port_inr[P_DATA]);
  assign xfer       = load_valid && load_ready;
  assign busy       = (state_q == ST_CLEAR);

  always_comb begin
    we    = 1'b0;
    waddr = cnt_q;
    wdata = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        we = 1'b1;
      end else if (!data_rd_wr && port_inr[P_DATA]) begin
        we    = 1'b1;
        waddr = port_idx[P_DATA];
        wdata = data_in;
      end else if (xfer && port_inr[P_LOAD]) begin
        we    = 1'b1;
        waddr = port_idx[P_LOAD];
        wdata = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    instr_d   = '0;
    data_d    = '0;
    err_mis_d = err_mis_q;
    err_rng_d = err_rng_q;
    if (state_q == ST_READY) begin
      if (port_inr[P_INSTR]) instr_d = mem[port_idx[P_INSTR]];
      if (port_inr[P_DATA])  data_d  = mem[port_idx[P_DATA]];
      if (!port_inr[P_INSTR] || !port_inr[P_DATA] || (xfer && !port_inr[P_LOAD])) begin
        err_rng_d = 1'b1;
      end
      if (port_mis[P_INSTR] || port_mis[P_DATA] || (xfer && port_mis[P_LOAD])) begin
        err_mis_d = 1'b1;
      end
    end
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      data_q    <= '0;
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      data_q    <= data_d;
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
    end
  end

  assign instr_out      = instr_q;
  assign data_out       = data_q;
  assign err_misaligned = err_mis_q;
  assign err_range      = err_rng_q;

endmodule

// File: tb/tb_mips_memory.sv
// Bench for mips_memory: a 1024-word instance checked against an array model,
// and a 16-word clear-on-reset instance checked for clear timing and restart.
module tb_mips_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: depth 1024, base 0, no clear.
  logic        rst_a = 1'b1;
  logic [31:0] ia_a = '0, da_a = '0, din_a = '0, la_a = '0, ld_a = '0;
  logic        rw_a = 1'b1, lv_a = 1'b0;
  logic [31:0] io_a, do_a;
  logic        lr_a, busy_a, em_a, er_a;

  mips_memory #(.depth_words(1024), .base_addr(32'h0), .clear_on_reset(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .instr_addr(ia_a), .instr_out(io_a),
    .data_rd_wr(rw_a), .data_addr(da_a), .data_in(din_a), .data_out(do_a),
    .load_valid(lv_a), .load_ready(lr_a), .load_addr(la_a), .load_data(ld_a),
    .busy(busy_a), .err_misaligned(em_a), .err_range(er_a)
  );

  // Instance B: depth 16, clear on reset.
  logic        rst_b = 1'b1;
  logic [31:0] ia_b = '0, da_b = '0, din_b = '0, la_b = '0, ld_b = '0;
  logic        rw_b = 1'b1, lv_b = 1'b0;
  logic [31:0] io_b, do_b;
  logic        lr_b, busy_b, em_b, er_b;

  mips_memory #(.depth_words(16), .base_addr(32'h0), .clear_on_reset(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .instr_addr(ia_b), .instr_out(io_b),
    .data_rd_wr(rw_b), .data_addr(da_b), .data_in(din_b), .data_out(do_b),
    .load_valid(lv_b), .load_ready(lr_b), .load_addr(la_b), .load_data(ld_b),
    .busy(busy_b), .err_misaligned(em_b), .err_range(er_b)
  );

  // Reference model for instance A.
  bit [31:0] mm [1024];
  bit        kn [1024];
  bit        m_mis = 1'b0;
  bit        m_rng = 1'b0;

  function automatic bit inr(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  task automatic step_a(input logic [31:0] ia, input logic rw, input logic [31:0] da,
                        input logic [31:0] din, input logic lv, input logic [31:0] la,
                        input logic [31:0] ld);
    logic [31:0] e_i, e_d;
    bit v_i, v_d, e_lr, x;
    @(negedge clk);
    ia_a = ia; rw_a = rw; da_a = da; din_a = din; lv_a = lv; la_a = la; ld_a = ld;
    #1;
    e_lr = rw || !inr(da);
    n_cmp++;
    if (lr_a !== e_lr) begin
      n_err++;
      $display("FAIL load_ready da=%h rw=%b got=%b exp=%b", da, rw, lr_a, e_lr);
    end
    e_i = '0; v_i = 1'b1;
    if (inr(ia)) begin e_i = mm[ia[11:2]]; v_i = kn[ia[11:2]]; end
    e_d = '0; v_d = 1'b1;
    if (inr(da)) begin e_d = mm[da[11:2]]; v_d = kn[da[11:2]]; end
    x = lv && e_lr;
    if (!rw && inr(da)) begin
      mm[da[11:2]] = din; kn[da[11:2]] = 1'b1;
    end else if (x && inr(la)) begin
      mm[la[11:2]] = ld; kn[la[11:2]] = 1'b1;
    end
    if (!inr(ia) || !inr(da) || (x && !inr(la))) m_rng = 1'b1;
    if (ia[1:0] != 2'b00 || da[1:0] != 2'b00 || (x && la[1:0] != 2'b00)) m_mis = 1'b1;
    @(posedge clk);
    #1;
    if (v_i) begin
      n_cmp++;
      if (io_a !== e_i) begin
        n_err++;
        $display("FAIL instr_out ia=%h got=%h exp=%h", ia, io_a, e_i);
      end
    end
    if (v_d) begin
      n_cmp++;
      if (do_a !== e_d) begin
        n_err++;
        $display("FAIL data_out da=%h got=%h exp=%h", da, do_a, e_d);
      end
    end
    n_cmp++;
    if (em_a !== m_mis || er_a !== m_rng || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL flags got mis=%b rng=%b busy=%b exp mis=%b rng=%b busy=0",
               em_a, er_a, busy_a, m_mis, m_rng);
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1; lv_a = 1'b1; rw_a = 1'b1; da_a = 32'h4; ia_a = 32'h3;
    #1;
    n_cmp++;
    if (lr_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_load_ready got=%b exp=0", lr_a);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_a !== 32'h0 || do_a !== 32'h0 || em_a !== 1'b0 || er_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got io=%h do=%h mis=%b rng=%b busy=%b exp all 0",
               io_a, do_a, em_a, er_a, busy_a);
    end
    m_mis = 1'b0; m_rng = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; lv_a = 1'b0; rw_a = 1'b1; da_a = '0; ia_a = '0;
  endtask

  task automatic test_reset();
    reset_a();
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h2402_0005 : (i == 1) ? 32'h0 : $urandom;
      step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 32'(i) << 2, v);
    end
    step_a(32'h0, 1'b1, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);
    $display("test_fill done, instr_out @0 = %h", io_a);
  endtask

  task automatic test_write_hold();
    repeat (3) step_a(32'h0, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h200, 32'h1234_5678);
    step_a(32'h0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
    step_a(32'h200, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0, 32'h0);
    $display("test_write_hold done, data_out=%h", do_a);
  endtask

  task automatic test_read_first();
    step_a(32'h0, 1'b0, 32'h40, 32'h11, 1'b0, 32'h0, 32'h0);
    step_a(32'h40, 1'b0, 32'h40, 32'h22, 1'b0, 32'h0, 32'h0);
    step_a(32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0);
    $display("test_read_first done, data_out=%h", do_a);
  endtask

  task automatic test_back_to_back();
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h300, 32'hA5A5_0001);
    step_a(32'h300, 1'b1, 32'h304, 32'h0, 1'b1, 32'h304, 32'hA5A5_0002);
    step_a(32'h304, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0, 32'h0);
    $display("test_back_to_back done");
  endtask

  task automatic test_errors();
    step_a(32'h0, 1'b1, 32'h1002, 32'h0, 1'b0, 32'h0, 32'h0);
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step_a(32'h0, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_a();
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h6, 32'h0BAD_0006);
    step_a(32'h4, 1'b1, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_a();
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h2000, 32'h0BAD_2000);
    step_a(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_a();
    step_a(32'h4000, 1'b1, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_a();
    $display("test_errors done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ia, da, la;
      ia = {20'h0, 6'($urandom_range(0, 63)), 4'h0, 2'b00};
      da = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
      la = {22'h0, 8'($urandom_range(0, 31)), 2'b00};
      if (i >= 300) begin
        if ($urandom_range(0, 7) == 0) da = da | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) la = la + 32'h1000;
        if ($urandom_range(0, 7) == 0) ia = ia | 32'h8000;
      end
      step_a(ia, 1'($urandom), da, $urandom, 1'($urandom), la, $urandom);
    end
    @(negedge clk);
    lv_a = 1'b0; rw_a = 1'b1; da_a = '0; ia_a = '0;
    $display("test_random done");
  endtask

  task automatic count_busy_b(output int cnt);
    cnt = 0;
    while (busy_b === 1'b1 && cnt < 40) begin
      n_cmp++;
      if (lr_b !== 1'b0 || do_b !== 32'h0 || io_b !== 32'h0) begin
        n_err++;
        $display("FAIL clear_outputs cyc=%0d got lr=%b do=%h io=%h exp 0", cnt, lr_b, do_b, io_b);
      end
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_clear();
    int cnt;
    count_busy_b(cnt);
    @(negedge clk);
    rw_b = 1'b1; lv_b = 1'b1; la_b = 32'h14; ld_b = 32'hAA; da_b = 32'h14; ia_b = 32'h14;
    @(negedge clk);
    lv_b = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (do_b !== 32'hAA) begin
      n_err++;
      $display("FAIL preload got=%h exp=000000aa", do_b);
    end
    @(negedge clk);
    rst_b = 1'b1; lv_b = 1'b1; rw_b = 1'b0; din_b = 32'hFF;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    count_busy_b(cnt);
    rw_b = 1'b1; lv_b = 1'b0;
    n_cmp++;
    if (cnt != 16) begin
      n_err++;
      $display("FAIL clear_length got=%0d exp=16", cnt);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (do_b !== 32'h0 || io_b !== 32'h0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL cleared_word got do=%h io=%h busy=%b exp 0", do_b, io_b, busy_b);
    end
    n_cmp++;
    if (lr_b !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_clear got lr=%b exp=1", lr_b);
    end
    $display("test_clear done, busy cycles=%0d", cnt);
  endtask

  task automatic test_clear_restart();
    int cnt;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (busy_b !== 1'b1) begin
      n_err++;
      $display("FAIL busy_mid_clear got=%b exp=1", busy_b);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    count_busy_b(cnt);
    n_cmp++;
    if (cnt != 16) begin
      n_err++;
      $display("FAIL clear_restart_length got=%0d exp=16", cnt);
    end
    $display("test_clear_restart done, busy cycles=%0d", cnt);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    test_reset();
    test_fill();
    test_write_hold();
    test_read_first();
    test_back_to_back();
    test_errors();
    test_random();
    test_clear();
    test_clear_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
